mem_port_arbiter: RTL

Shares the single off-chip memory port between the instruction-cache fill path and the data-side memory stage.
- Each side issues line reads (cache fills); the data side also issues word writes.
- The arbiter serializes requests, drives the memory strobes for a fixed latency, and returns the 64-bit line with a one-cycle done pulse.
- Sits between the IF/MEM stages and the memory model, replacing the per-stage `readM`/`writeM` drive.

---
 rtl/mem_port_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one off-chip memory port between the instruction
// fill path and the data-side memory stage. Requests are serialized through
// IDLE -> ACCESS -> DONE, with the strobes held for MEM_LATENCY cycles and a
// one-cycle done pulse to the owner.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin tie-break;
// when undefined the data side always wins a tie).

module mem_port_arbiter #(
  parameter int MEM_LATENCY = 4,
  parameter int WORD_SIZE   = 16,
  parameter int LINE_SIZE   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [LINE_SIZE-1:0] i_rdata,
  output logic                 i_done,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [LINE_SIZE-1:0] d_rdata,
  output logic                 d_done,
  output logic                 m_readM,
  output logic                 m_writeM,
  output logic [WORD_SIZE-1:0] m_address,
  output logic [LINE_SIZE-1:0] m_data_out,
  output logic                 m_data_oe,
  input  logic [LINE_SIZE-1:0] m_data_in,
  output logic                 busy,
  output logic                 owner
);

  // Counter holds MEM_LATENCY-1 down to 0; at least one bit wide.
  localparam int              CW       = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(MEM_LATENCY - 1);
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam int              PAD      = LINE_SIZE - WORD_SIZE;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t                 state_r, state_s;
  logic                   owner_s;
  logic [WORD_SIZE-1:0]   addr_r, addr_s;
  logic                   we_r, we_s;
  logic [WORD_SIZE-1:0]   wdata_r, wdata_s;
  logic [CW-1:0]          cnt_r, cnt_s;
  logic                   grant_d_s;
  logic                   capture_s;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 1 when the data side received the most recent grant.
  logic                   last_d_r;
`endif

  // Tie-break between the two requesters (only meaningful in IDLE).
  always_comb begin
    grant_d_s = 1'b0;
    if (d_req && !i_req) begin
      grant_d_s = 1'b1;
    end else if (d_req && i_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      grant_d_s = !last_d_r;
`else
      grant_d_s = 1'b1;
`endif
    end else begin
      grant_d_s = 1'b0;
    end
  end

  // Next-state and latched-transaction logic.
  always_comb begin
    state_s   = state_r;
    owner_s   = owner;
    addr_s    = addr_r;
    we_s      = we_r;
    wdata_s   = wdata_r;
    cnt_s     = cnt_r;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_req || d_req) begin
          owner_s = grant_d_s;
          addr_s  = grant_d_s ? d_addr : i_addr;
          we_s    = grant_d_s & d_we;
          wdata_s = grant_d_s ? d_wdata : {WORD_SIZE{1'b0}};
          cnt_s   = CNT_LOAD;
          state_s = ST_ACCESS;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_r == CNT_ZERO) begin
          capture_s = !we_r;
          state_s   = ST_DONE;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register and latched transaction fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      addr_r  <= {WORD_SIZE{1'b0}};
      we_r    <= 1'b0;
      wdata_r <= {WORD_SIZE{1'b0}};
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
      we_r    <= we_s;
      wdata_r <= wdata_s;
      cnt_r   <= cnt_s;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Round-robin pointer: remembers which side won the last grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_d_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && (i_req || d_req)) begin
      last_d_r <= grant_d_s;
    end else begin
      last_d_r <= last_d_r;
    end
  end
`endif

  // Registered memory strobes, status and per-side result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_readM    <= 1'b0;
      m_writeM   <= 1'b0;
      m_data_oe  <= 1'b0;
      m_address  <= {WORD_SIZE{1'b0}};
      m_data_out <= {LINE_SIZE{1'b0}};
      busy       <= 1'b0;
      owner      <= 1'b0;
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      i_rdata    <= {LINE_SIZE{1'b0}};
      d_rdata    <= {LINE_SIZE{1'b0}};
    end else begin
      m_readM    <= (state_s == ST_ACCESS) && !we_s;
      m_writeM   <= (state_s == ST_ACCESS) && we_s;
      m_data_oe  <= (state_s == ST_ACCESS) && we_s;
      m_address  <= (state_s == ST_ACCESS) ? addr_s : {WORD_SIZE{1'b0}};
      m_data_out <= ((state_s == ST_ACCESS) && we_s) ? {wdata_s, {PAD{1'b0}}}
                                                     : {LINE_SIZE{1'b0}};
      busy       <= (state_s != ST_IDLE);
      owner      <= owner_s;
      i_done     <= (state_s == ST_DONE) && !owner_s;
      d_done     <= (state_s == ST_DONE) && owner_s;
      if (capture_s && !owner) begin
        i_rdata <= m_data_in;
      end else begin
        i_rdata <= i_rdata;
      end
      if (capture_s && owner) begin
        d_rdata <= m_data_in;
      end else begin
        d_rdata <= d_rdata;
      end
    end
  end

endmodule
